// File: rtl/mac_pkg.sv
// Shared widths, FSM state encoding and saturation limits for the MAC accumulation stage.
// Pure declarations: no latency, no flow control.
package mac_pkg;

    localparam int MAN_W  = 16;
    localparam int EXP_W  = 4;
    localparam int TERM_W = 32;
    // Widest aligned magnitude: 16-bit mantissa shifted left by up to 15.
    localparam int MAG_W  = MAN_W + (1 << EXP_W) - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    function automatic logic [63:0] sat_max(input int unsigned acc_w);
        return (64'd1 << (acc_w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int unsigned acc_w);
        return 64'd1 << (acc_w - 1);
    endfunction

endpackage

// File: rtl/mac_align.sv
// Stage 1: align a sign/magnitude product by its exponent and register it as a two's-complement term.
// One-cycle latency; no backpressure, the caller qualifies loading with accept_i.
module mac_align
    import mac_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              accept_i,
    input  logic [MAN_W-1:0]  man_i,
    input  logic [EXP_W-1:0]  exp_i,
    input  logic              sgn_i,
    output logic [TERM_W-1:0] term_o,
    output logic              term_vld_o
);

    logic [MAG_W-1:0]  mag;
    logic [TERM_W-1:0] term_d;
    logic [TERM_W-1:0] term_q;
    logic              vld_q;

    always_comb begin
        mag    = MAG_W'(man_i) << exp_i;
        // Negating a zero magnitude yields zero, so a -0 product adds nothing.
        term_d = sgn_i ? -{1'b0, mag} : {1'b0, mag};
    end

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            term_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            vld_q <= accept_i;
            if (accept_i) begin
                term_q <= term_d;
            end
        end
    end

    assign term_o     = term_q;
    assign term_vld_o = vld_q;

endmodule

// File: rtl/mac_acc.sv
// Saturating dot-product accumulator fed by the multiplier; result offered on a valid/ready port.
// Two-cycle pipeline (align, add); result is held until out_ready, input never stalls and excess products are flagged.
module mac_acc
    import mac_pkg::*;
#(
    parameter int ACC_W = 40,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             start,
    input  logic             in_valid,
    input  logic [MAN_W-1:0] in_man,
    input  logic [EXP_W-1:0] in_exp,
    input  logic             in_sgn,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_ovf,
    output logic             busy,
    output logic             err_drop
);

    localparam int CNT_W = LEN_W + 1;
    localparam logic [ACC_W-1:0] ACC_MAX = ACC_W'(sat_max(ACC_W));
    localparam logic [ACC_W-1:0] ACC_MIN = ACC_W'(sat_min(ACC_W));

    if (ACC_W < 32 || ACC_W > 64) begin : g_bad_width
        $error("mac_acc: ACC_W must lie in 32..64");
    end

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               ovf_q, ovf_d;
    logic               err_q, err_d;

    logic               start_acc;
    logic               accept;
    logic               drop;
    logic [CNT_W-1:0]   cnt_load;
    logic [TERM_W-1:0]  term;
    logic               term_vld;
    logic [ACC_W-1:0]   term_ext;
    logic [ACC_W:0]     sum;
    logic               sum_ovf;

    // A start in HOLD only counts when the pending result is consumed in the same cycle.
    assign start_acc = start && ((state_q != HOLD) || out_ready);
    // The start cycle reloads the count, so a product arriving with it is not accumulated.
    assign accept    = in_valid && (state_q == ACCUM) && !start_acc;
    assign drop      = in_valid && (state_q != ACCUM);
    assign cnt_load  = (cfg_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, cfg_len};

    mac_align u_align (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (start_acc),
        .accept_i   (accept),
        .man_i      (in_man),
        .exp_i      (in_exp),
        .sgn_i      (in_sgn),
        .term_o     (term),
        .term_vld_o (term_vld)
    );

    assign term_ext = ACC_W'($signed(term));
    assign sum      = {acc_q[ACC_W-1], acc_q} + {term_ext[ACC_W-1], term_ext};
    assign sum_ovf  = sum[ACC_W] ^ sum[ACC_W-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        err_d   = (err_q & ~start) | drop;

        if (term_vld) begin
            if (sum_ovf) begin
                acc_d = sum[ACC_W] ? ACC_MIN : ACC_MAX;
                ovf_d = 1'b1;
            end else begin
                acc_d = sum[ACC_W-1:0];
            end
        end

        if (accept) begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        case (state_q)
            IDLE:    if (start) state_d = ACCUM;
            ACCUM:   if (accept && cnt_q == CNT_W'(1)) state_d = DRAIN;
            DRAIN:   state_d = HOLD;
            HOLD:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (start_acc) begin
            state_d = ACCUM;
            cnt_d   = cnt_load;
            acc_d   = '0;
            ovf_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == HOLD);
    assign busy      = (state_q != IDLE);
    assign out_data  = acc_q;
    assign out_ovf   = ovf_q;
    assign err_drop  = err_q;

endmodule

// File: tb/tb_mac_acc.sv
// Directed bench for mac_acc: a 40-bit and a 32-bit instance share every input.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_mac_acc;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  cfg_len;
    logic        start;
    logic        in_valid;
    logic [15:0] in_man;
    logic [3:0]  in_exp;
    logic        in_sgn;
    logic        out_ready;

    logic        a_in_ready, a_out_valid, a_out_ovf, a_busy, a_err_drop;
    logic [39:0] a_out_data;
    logic        b_in_ready, b_out_valid, b_out_ovf, b_busy, b_err_drop;
    logic [31:0] b_out_data;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mac_acc #(.ACC_W(40), .LEN_W(8)) dut_a (
        .clk(clk), .rst(rst), .cfg_len(cfg_len), .start(start),
        .in_valid(in_valid), .in_man(in_man), .in_exp(in_exp), .in_sgn(in_sgn),
        .in_ready(a_in_ready), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_data(a_out_data), .out_ovf(a_out_ovf), .busy(a_busy), .err_drop(a_err_drop)
    );

    mac_acc #(.ACC_W(32), .LEN_W(8)) dut_b (
        .clk(clk), .rst(rst), .cfg_len(cfg_len), .start(start),
        .in_valid(in_valid), .in_man(in_man), .in_exp(in_exp), .in_sgn(in_sgn),
        .in_ready(b_in_ready), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_data(b_out_data), .out_ovf(b_out_ovf), .busy(b_busy), .err_drop(b_err_drop)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] len);
        cfg_len = len;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic push(input logic [15:0] m, input logic [3:0] e, input logic s);
        in_valid = 1'b1;
        in_man   = m;
        in_exp   = e;
        in_sgn   = s;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic finish_hold();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_vec++; if (a_in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b want 0", a_in_ready); end
        n_vec++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", a_out_valid); end
        n_vec++; if (a_busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", a_busy); end
        n_vec++; if (a_out_data !== 40'd0) begin n_err++; $display("FAIL rst_out_data: got %h want 0", a_out_data); end
        n_vec++; if ({a_out_ovf, a_err_drop} !== 2'b00) begin n_err++; $display("FAIL rst_flags: got %b want 00", {a_out_ovf, a_err_drop}); end
    endtask

    task automatic test_basic();
        do_start(8'd2);
        n_vec++; if ({a_in_ready, a_busy} !== 2'b11) begin n_err++; $display("FAIL basic_accum_entry: got %b want 11", {a_in_ready, a_busy}); end
        push(16'h0100, 4'd2, 1'b0);
        push(16'h0040, 4'd0, 1'b1);
        n_vec++; if ({a_out_valid, a_in_ready} !== 2'b00) begin n_err++; $display("FAIL basic_drain: got %b want 00", {a_out_valid, a_in_ready}); end
        tick();
        n_vec++; if (a_out_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid_t2: got %b want 1", a_out_valid); end
        n_vec++; if (a_out_data !== 40'd960) begin n_err++; $display("FAIL basic_data: got %0d want 960", a_out_data); end
        n_vec++; if ({a_out_ovf, a_err_drop} !== 2'b00) begin n_err++; $display("FAIL basic_flags: got %b want 00", {a_out_ovf, a_err_drop}); end
        finish_hold();
        n_vec++; if ({a_out_valid, a_busy} !== 2'b00) begin n_err++; $display("FAIL basic_idle: got %b want 00", {a_out_valid, a_busy}); end
    endtask

    task automatic test_neg_zero();
        do_start(8'd3);
        push(16'h0000, 4'd3, 1'b1);
        push(16'h0001, 4'd15, 1'b1);
        push(16'hFFFF, 4'd0, 1'b0);
        tick();
        n_vec++; if (a_out_data !== 40'd32767) begin n_err++; $display("FAIL negzero_data: got %h want 7fff", a_out_data); end
        finish_hold();
    endtask

    task automatic test_full_scale();
        do_start(8'd0);
        for (int i = 0; i < 255; i++) push(16'hFFFF, 4'd15, 1'b0);
        n_vec++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL full_len256_ready: got %b want 1", a_in_ready); end
        push(16'hFFFF, 4'd15, 1'b0);
        tick();
        n_vec++; if (a_out_data !== 40'h7FFF800000) begin n_err++; $display("FAIL full_data40: got %h want 7fff800000", a_out_data); end
        n_vec++; if (a_out_ovf !== 1'b0) begin n_err++; $display("FAIL full_ovf40: got %b want 0", a_out_ovf); end
        n_vec++; if ({b_out_data, b_out_ovf} !== {32'h7FFFFFFF, 1'b1}) begin n_err++; $display("FAIL full_sat32: got %h/%b want 7fffffff/1", b_out_data, b_out_ovf); end
        finish_hold();
    endtask

    task automatic test_saturation();
        do_start(8'd2);
        push(16'hFFFF, 4'd15, 1'b0);
        push(16'hFFFF, 4'd15, 1'b0);
        tick();
        n_vec++; if ({b_out_data, b_out_ovf} !== {32'h7FFFFFFF, 1'b1}) begin n_err++; $display("FAIL sat_pos32: got %h/%b want 7fffffff/1", b_out_data, b_out_ovf); end
        n_vec++; if ({a_out_data, a_out_ovf} !== {40'h00FFFF0000, 1'b0}) begin n_err++; $display("FAIL sat_pos40: got %h/%b want 00ffff0000/0", a_out_data, a_out_ovf); end
        finish_hold();
        do_start(8'd2);
        n_vec++; if (b_out_ovf !== 1'b0) begin n_err++; $display("FAIL sat_ovf_clear: got %b want 0", b_out_ovf); end
        push(16'hFFFF, 4'd15, 1'b1);
        push(16'hFFFF, 4'd15, 1'b1);
        tick();
        n_vec++; if ({b_out_data, b_out_ovf} !== {32'h80000000, 1'b1}) begin n_err++; $display("FAIL sat_neg32: got %h/%b want 80000000/1", b_out_data, b_out_ovf); end
        n_vec++; if ({a_out_data, a_out_ovf} !== {40'hFF00010000, 1'b0}) begin n_err++; $display("FAIL sat_neg40: got %h/%b want ff00010000/0", a_out_data, a_out_ovf); end
        finish_hold();
    endtask

    task automatic test_back_to_back();
        do_start(8'd1);
        push(16'h1234, 4'd4, 1'b0);
        tick();
        for (int i = 0; i < 5; i++) begin
            n_vec++; if ({a_out_valid, a_out_data} !== {1'b1, 40'h0000012340}) begin n_err++; $display("FAIL hold_stable[%0d]: got %b/%h want 1/12340", i, a_out_valid, a_out_data); end
            tick();
        end
        out_ready = 1'b1;
        start     = 1'b1;
        cfg_len   = 8'd1;
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        n_vec++; if ({a_in_ready, a_out_valid} !== 2'b10) begin n_err++; $display("FAIL b2b_turnaround: got %b want 10", {a_in_ready, a_out_valid}); end
        n_vec++; if (a_out_data !== 40'd0) begin n_err++; $display("FAIL b2b_cleared: got %h want 0", a_out_data); end
        push(16'h0003, 4'd0, 1'b1);
        tick();
        n_vec++; if (a_out_data !== 40'hFFFFFFFFFD) begin n_err++; $display("FAIL b2b_data: got %h want fffffffffd", a_out_data); end
        finish_hold();
    endtask

    task automatic test_abort_drop();
        do_start(8'd5);
        for (int i = 0; i < 3; i++) push(16'd1000, 4'd0, 1'b0);
        do_start(8'd5);
        n_vec++; if ({a_in_ready, a_out_data} !== {1'b1, 40'd0}) begin n_err++; $display("FAIL abort_clear: got %b/%h want 1/0", a_in_ready, a_out_data); end
        for (int i = 1; i <= 5; i++) push(16'(i), 4'd0, 1'b0);
        push(16'hFFFF, 4'd15, 1'b0);
        n_vec++; if ({a_out_valid, a_out_data} !== {1'b1, 40'd15}) begin n_err++; $display("FAIL abort_data: got %b/%0d want 1/15", a_out_valid, a_out_data); end
        n_vec++; if (a_err_drop !== 1'b1) begin n_err++; $display("FAIL drop_set: got %b want 1", a_err_drop); end
        finish_hold();
        n_vec++; if (a_err_drop !== 1'b1) begin n_err++; $display("FAIL drop_sticky: got %b want 1", a_err_drop); end
        do_start(8'd1);
        n_vec++; if (a_err_drop !== 1'b0) begin n_err++; $display("FAIL drop_cleared: got %b want 0", a_err_drop); end
        push(16'd1, 4'd0, 1'b0);
        tick();
        finish_hold();
    endtask

    task automatic test_reset_mid();
        do_start(8'd4);
        push(16'd5, 4'd0, 1'b0);
        push(16'd5, 4'd0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++; if ({a_in_ready, a_busy, a_out_valid, a_out_ovf, a_err_drop} !== 5'b0) begin n_err++; $display("FAIL midrst_ctrl: got %b want 00000", {a_in_ready, a_busy, a_out_valid, a_out_ovf, a_err_drop}); end
        n_vec++; if (a_out_data !== 40'd0) begin n_err++; $display("FAIL midrst_data: got %h want 0", a_out_data); end
        tick();
        tick();
        tick();
        n_vec++; if (a_in_ready !== 1'b0) begin n_err++; $display("FAIL midrst_ready_low: got %b want 0", a_in_ready); end
        do_start(8'd1);
        push(16'd7, 4'd0, 1'b0);
        tick();
        n_vec++; if ({a_out_valid, a_out_data} !== {1'b1, 40'd7}) begin n_err++; $display("FAIL midrst_restart: got %b/%0d want 1/7", a_out_valid, a_out_data); end
        finish_hold();
    endtask

    initial begin
        rst       = 1'b1;
        cfg_len   = 8'd0;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_man    = 16'd0;
        in_exp    = 4'd0;
        in_sgn    = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_neg_zero();
        test_full_scale();
        test_saturation();
        test_back_to_back();
        test_abort_drop();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mac_acc.md
# mac_acc

Accumulation stage directly downstream of the multiplier in the quantization MAC datapath. It consumes one sign/magnitude product per cycle (16-bit mantissa, 4-bit exponent, sign). Each product is aligned by its exponent, converted to two's complement and summed into a saturating ACC_W-bit accumulator over a programmed vector length. The finished dot product is presented on a valid/ready output port.

## Interface
- ACC_W, 40, accumulator/output width; legal range 32..64.
- LEN_W, 8, width of the vector-length field.

- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_len  in  LEN_W  products per dot product, sampled on accepted start; 0 means 2^LEN_W.
- start  in  1  pulse: clear accumulator, load length, begin accumulation.
- in_valid  in  1  product valid; aligned with the multiplier's 2-cycle output.
- in_man  in  16  unsigned product mantissa.
- in_exp  in  4  product exponent (0..15); left-shift amount.
- in_sgn  in  1  product sign, 1 = negative.
- in_ready  out  1  high only in ACCUM; the upstream does not stall.
- out_valid  out  1  dot-product result valid; held until out_ready.
- out_ready  in  1  consumer accepts the result.
- out_data  out  ACC_W  signed two's-complement result.
- out_ovf  out  1  saturation occurred during this dot product.
- busy  out  1  state is not IDLE.
- err_drop  out  1  sticky: in_valid seen while in_ready low; cleared by start or rst.

## Operation
- States:
  - IDLE: start → ACCUM.
  - ACCUM: accept in_valid products while counting down.
  - DRAIN: single cycle.
  - HOLD: assert out_valid.
- Per-product term: mag = in_man << in_exp, 31 bits. term = in_sgn ? -mag : mag, sign-extended to ACC_W. A -0 product contributes 0.
- Accumulate: sum = acc + term, computed in ACC_W+1 bits.
  - On signed overflow, acc saturates to +(2^(ACC_W-1)-1) or -2^(ACC_W-1) and out_ovf is set.
  - out_ovf stays set until the next start.
- Counter:
  - Loaded with cfg_len on start; 0 loads 2^LEN_W.
  - Decremented per accepted product.
  - Acceptance with count==1 is the last product: ACCUM → DRAIN.
- DRAIN → HOLD unconditionally.
- HOLD: out_valid=1 and out_data = acc.
  - out_ready → IDLE.
  - out_ready and start in the same cycle → ACCUM with the accumulator cleared; the completed result is consumed that cycle.
- start in ACCUM or DRAIN aborts the current dot product:
  - accumulator, pipeline term register and out_ovf are cleared;
  - the count is reloaded;
  - next state is ACCUM.
- in_valid while not in ACCUM: the product is discarded and err_drop is set.
- Reset: IDLE; acc, term register, counter, out_data, out_valid, out_ovf, busy, err_drop, in_ready all 0.

## Timing
- Two-stage pipeline:
  - Stage 1 registers the aligned/negated term.
  - Stage 2 adds the term into acc.
- Last product accepted at cycle t: term registered at t+1, acc final at t+2. State is DRAIN at t+1 and HOLD at t+2, so out_valid rises at t+2.
- in_ready is a registered-state decode and falls at t+1. The upstream must gap products between dot products; dropped products are flagged only, never queued.
- Throughput: one product per cycle in ACCUM, with no bubbles.
- out_data is stable while out_valid=1 and out_ready=0.
- Minimum turnaround: start in the HOLD acceptance cycle → in_ready=1 on the next cycle.

## Structure
- Package mac_pkg:
  - MAN_W=16, EXP_W=4, TERM_W=32;
  - state enum {IDLE, ACCUM, DRAIN, HOLD};
  - saturation-limit functions parameterised by ACC_W.
- Sub-module mac_align: stage 1, comprising the shift, conditional negate, sign-extend and valid register. The top level holds the FSM, counter, saturating adder and output register.

## Test plan
- Basic sum: cfg_len=2; products (man=0x0100, exp=2, sgn=0) then (man=0x0040, exp=0, sgn=1) → out_data=960 and out_ovf=0, out_valid 2 cycles after the second product.
- Full-scale stream: cfg_len=0, 256 products of (0xFFFF, 15, 0) at ACC_W=40 → out_data = 256·0x7FFF8000 = 0x7FFF800000, no ovf.
- Saturation at ACC_W=32:
  - two products of (0xFFFF, 15, 0) → out_data=0x7FFFFFFF, out_ovf=1;
  - negative counterpart → 0x80000000, out_ovf=1.
- Backpressure/restart:
  - hold out_ready=0 for 5 cycles → out_data constant;
  - then out_ready=1 with start=1 in the same cycle → next cycle in_ready=1 and the new sum starts from 0.
- Abort and drops:
  - start after 3 of 5 products → result equals only the post-restart products;
  - in_valid during DRAIN → product ignored, err_drop=1 until the next start.
- Reset mid-ACCUM: assert rst for 1 cycle → all outputs 0 and state IDLE; in_ready stays 0 until start.
